// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register with valid/ready flow control, flush,
// and an optional two-entry skid buffer that registers the upstream ready.
module pipe_stage_reg #(
  parameter int CTRL_W  = 8,
  parameter int DATA_W  = 154,
  parameter int SKID_EN = 0
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  // State value doubles as the occupancy count.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  localparam logic [1:0] MAX_OCC = (SKID_EN != 0) ? 2'd2 : 2'd1;

  state_t            state, state_nxt;
  logic              ready_q;
  logic              accept, drain;
  logic              load_main, load_skid, skid_to_main;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
  logic [DATA_W-1:0] main_data, skid_data;

  assign out_valid = (state != ST_EMPTY);
  // ready_q holds ready low during reset and, with the skid buffer, is the registered ready itself.
  assign in_ready  = (SKID_EN != 0) ? ready_q : (ready_q & (!out_valid | out_ready));
  assign accept    = in_valid & in_ready;
  assign drain     = out_valid & out_ready;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
    state_nxt    = state;
    load_main    = 1'b0;
    load_skid    = 1'b0;
    skid_to_main = 1'b0;
    if (flush) begin
      state_nxt = ST_EMPTY;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (accept) begin
            state_nxt = ST_ONE;
            load_main = 1'b1;
          end
        end
        ST_ONE: begin
          if (accept && drain) begin
            load_main = 1'b1;
          end else if (accept) begin
            // Only reachable with the skid buffer: without it, accepting while full implies a drain.
            state_nxt = ST_TWO;
            load_skid = 1'b1;
          end else if (drain) begin
            state_nxt = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (drain) begin
            state_nxt    = ST_ONE;
            skid_to_main = 1'b1;
          end
        end
        default: state_nxt = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    if (!resetn) begin
      state   <= ST_EMPTY;
      ready_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      ready_q <= (SKID_EN != 0) ? (state_nxt != ST_TWO) : 1'b1;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    // NOTE: the payload registers are reset too, because out_data must read zero after reset.
    if (!resetn) begin
      main_ctrl <= '0;
      main_data <= '0;
      skid_ctrl <= '0;
      skid_data <= '0;
    end else begin
      if (load_main) begin
        main_ctrl <= in_ctrl;
        main_data <= in_data;
      end else if (skid_to_main) begin
        main_ctrl <= skid_ctrl;
        main_data <= skid_data;
      end
      if (load_skid) begin
        skid_ctrl <= in_ctrl;
        skid_data <= in_data;
      end
    end
  end

  // Bubbles carry no control, so a downstream stage never sees a stray write enable.
  assign out_ctrl  = out_valid ? main_ctrl : '0;
  assign out_data  = main_data;
  assign occupancy = state;

  occupancy_bound: assert property (@(posedge clock) disable iff (!resetn) occupancy <= MAX_OCC);

endmodule
